// File: rtl/bt_air_pkg.sv
// -----------------------------------------------------------------------------
// bt_air_pkg
// Shared definitions for the bt_air_channel air-interface model:
//   - LFSR tap mask and reset/lock-up-recovery seed
//   - counter saturation value and a saturating add helper
//   - air_t: one node's over-the-air state {en, fk, sym}
// air_t fields are sized for the largest supported frequency/symbol widths;
// narrower instances zero-extend into them.
// -----------------------------------------------------------------------------
package bt_air_pkg;

  // x^16 + x^14 + x^13 + x^11 + 1 as a left-shifting Fibonacci register:
  // feedback is the XOR of state bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_RST = 16'hACE1;

  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  localparam int AIR_FKW_MAX  = 8;
  localparam int AIR_SYMW_MAX = 8;

  typedef struct packed {
    logic                    en;
    logic [AIR_FKW_MAX-1:0]  fk;
    logic [AIR_SYMW_MAX-1:0] sym;
  } air_t;

  // Adds a small per-cycle increment (at most 8) and clamps at CNT_SAT.
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [3:0]  b);
    logic [16:0] s;
    s = {1'b0, a} + {13'b0, b};
    return s[16] ? CNT_SAT : s[15:0];
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/bt_air_lfsr.sv
// -----------------------------------------------------------------------------
// bt_air_lfsr
// 16-bit Fibonacci LFSR that advances every cycle. A load pulse has priority
// over advancing; loading an all-zero seed substitutes LFSR_SEED_RST so the
// register can never lock up.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (state <= LFSR_SEED_RST)
//   load_i   in   one-cycle pulse, load seed_i
//   seed_i   in   16-bit seed
//   state_o  out  current LFSR state
// -----------------------------------------------------------------------------
module bt_air_lfsr
  import bt_air_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  assign fb = ^(lfsr_q & LFSR_TAPS);

  always_comb begin
    lfsr_d = {lfsr_q[14:0], fb};
    if (load_i) begin
      lfsr_d = (seed_i == 16'h0000) ? LFSR_SEED_RST : seed_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED_RST;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/bt_air_channel.sv
// -----------------------------------------------------------------------------
// bt_air_channel
// Clocked air-interface model joining NODES baseband instances. Every node's
// {tx_en, tx_fk, tx_sym} travels through a DLY-deep delay line; the last stage
// is the "air". Each enabled receiver hears exactly one other transmitter on
// its current frequency (valid), nothing (idle) or several (collision).
// Received symbols can have bit 0 flipped by LFSR-driven error injection.
// Ports:
//   clk_6M       in   system clock
//   rst          in   asynchronous active-high reset
//   tx_en/tx_fk/tx_sym   in   per-node transmit state (node i at [i*W +: W])
//   rx_en/rx_fk          in   per-node receive enable / frequency
//   err_inj_en   in   enable error injection
//   err_thresh   in   inject when lfsr < err_thresh
//   seed         in   LFSR seed, loaded by seed_load_p
//   seed_load_p  in   one-cycle seed load pulse
//   clr_cnt_p    in   one-cycle counter clear pulse
//   rx_sym       out  per-node received symbol (registered)
//   rx_valid     out  per-node valid (registered)
//   collision    out  per-node collision flag (registered)
//   col_cnt      out  saturating collision receiver-cycle count
//   err_cnt      out  saturating injected-error count
// Latency from tx_* to rx_* is DLY+1 cycles.
// -----------------------------------------------------------------------------
module bt_air_channel
  import bt_air_pkg::*;
#(
  parameter int NODES = 4,
  parameter int SYMW  = 3,
  parameter int FKW   = 7,
  parameter int DLY   = 4
) (
  input  logic                    clk_6M,
  input  logic                    rst,
  input  logic [NODES-1:0]        tx_en,
  input  logic [NODES*FKW-1:0]    tx_fk,
  input  logic [NODES*SYMW-1:0]   tx_sym,
  input  logic [NODES-1:0]        rx_en,
  input  logic [NODES*FKW-1:0]    rx_fk,
  input  logic                    err_inj_en,
  input  logic [15:0]             err_thresh,
  input  logic [15:0]             seed,
  input  logic                    seed_load_p,
  input  logic                    clr_cnt_p,
  output logic [NODES*SYMW-1:0]   rx_sym,
  output logic [NODES-1:0]        rx_valid,
  output logic [NODES-1:0]        collision,
  output logic [15:0]             col_cnt,
  output logic [15:0]             err_cnt
);

  // ---------------------------------------------------------------------------
  // Delay line
  // ---------------------------------------------------------------------------
  air_t [NODES-1:0] tx_air;
  air_t [NODES-1:0] pipe_q [DLY];
  air_t [NODES-1:0] air_state;

  genvar gi;
  generate
    for (gi = 0; gi < NODES; gi++) begin : g_tx
      assign tx_air[gi] = '{en:  tx_en[gi],
                            fk:  AIR_FKW_MAX'(tx_fk[gi*FKW +: FKW]),
                            sym: AIR_SYMW_MAX'(tx_sym[gi*SYMW +: SYMW])};
    end
  endgenerate

  // Reset clears every stage at once so nothing launched before reset can
  // surface afterwards.
  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DLY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q[0] <= tx_air;
      for (int k = 1; k < DLY; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  assign air_state = pipe_q[DLY-1];

  // The symbol field is padded to AIR_SYMW_MAX; the pad bits are constant zero
  // and intentionally ignored.
  logic unused_air_pad;
  always_comb begin
    unused_air_pad = 1'b0;
    for (int i = 0; i < NODES; i++) begin
      unused_air_pad = unused_air_pad ^ (^air_state[i].sym);
    end
  end

  // ---------------------------------------------------------------------------
  // Error injection source
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr;
  logic        inject;

  bt_air_lfsr u_lfsr (
    .clk     (clk_6M),
    .rst     (rst),
    .load_i  (seed_load_p),
    .seed_i  (seed),
    .state_o (lfsr)
  );

  // err_thresh = 0 can never be exceeded, so it disables injection naturally.
  assign inject = err_inj_en && (lfsr < err_thresh);

  // ---------------------------------------------------------------------------
  // Per-receiver match logic
  // ---------------------------------------------------------------------------
  logic [NODES*SYMW-1:0] rx_sym_d;
  logic [NODES-1:0]      rx_valid_d;
  logic [NODES-1:0]      collision_d;

  generate
    for (gi = 0; gi < NODES; gi++) begin : g_rx
      logic [3:0]      hits;
      logic [SYMW-1:0] hit_sym;
      logic [SYMW-1:0] clean_sym;

      // Receiver frequency is sampled now, i.e. when the symbol leaves the
      // delay line, not when it was launched.
      always_comb begin
        hits    = '0;
        hit_sym = '0;
        for (int i = 0; i < NODES; i++) begin
          if ((i != gi) && air_state[i].en &&
              (air_state[i].fk == AIR_FKW_MAX'(rx_fk[gi*FKW +: FKW]))) begin
            hits    = hits + 4'd1;
            hit_sym = air_state[i].sym[SYMW-1:0];
          end
        end
      end

      assign rx_valid_d[gi]  = rx_en[gi] && (hits == 4'd1);
      assign collision_d[gi] = rx_en[gi] && (hits >= 4'd2);
      assign clean_sym       = rx_valid_d[gi] ? hit_sym : '0;
      assign rx_sym_d[gi*SYMW +: SYMW] =
        clean_sym ^ SYMW'(inject && rx_valid_d[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  logic [15:0] col_cnt_q, col_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [3:0]  col_inc;
  logic [3:0]  err_inc;

  assign col_inc = popcount8(8'(collision_d));
  assign err_inc = inject ? popcount8(8'(rx_valid_d)) : 4'd0;

  always_comb begin
    col_cnt_d = sat_add16(col_cnt_q, col_inc);
    err_cnt_d = sat_add16(err_cnt_q, err_inc);
    // A clear wins over this cycle's increments.
    if (clr_cnt_p) begin
      col_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [NODES*SYMW-1:0] rx_sym_q;
  logic [NODES-1:0]      rx_valid_q;
  logic [NODES-1:0]      collision_q;

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      rx_sym_q    <= '0;
      rx_valid_q  <= '0;
      collision_q <= '0;
      col_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      rx_sym_q    <= rx_sym_d;
      rx_valid_q  <= rx_valid_d;
      collision_q <= collision_d;
      col_cnt_q   <= col_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx_sym    = rx_sym_q;
  assign rx_valid  = rx_valid_q;
  assign collision = collision_q;
  assign col_cnt   = col_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bt_air_channel.sv
// -----------------------------------------------------------------------------
// tb_bt_air_channel
// Directed bench for bt_air_channel (NODES=4, SYMW=3, FKW=7, DLY=4).
// Steady-state match behaviour is table-driven; latency, counters, error
// injection and reset are hand-written sequences. The LFSR is modelled from
// its polynomial so the injection pattern is predicted independently.
// -----------------------------------------------------------------------------
module tb_bt_air_channel;

  localparam int NODES = 4;
  localparam int SYMW  = 3;
  localparam int FKW   = 7;
  localparam int DLY   = 4;

  logic                  clk_6M;
  logic                  rst;
  logic [NODES-1:0]      tx_en;
  logic [NODES*FKW-1:0]  tx_fk;
  logic [NODES*SYMW-1:0] tx_sym;
  logic [NODES-1:0]      rx_en;
  logic [NODES*FKW-1:0]  rx_fk;
  logic                  err_inj_en;
  logic [15:0]           err_thresh;
  logic [15:0]           seed;
  logic                  seed_load_p;
  logic                  clr_cnt_p;
  logic [NODES*SYMW-1:0] rx_sym;
  logic [NODES-1:0]      rx_valid;
  logic [NODES-1:0]      collision;
  logic [15:0]           col_cnt;
  logic [15:0]           err_cnt;

  bt_air_channel #(
    .NODES(NODES), .SYMW(SYMW), .FKW(FKW), .DLY(DLY)
  ) dut (
    .clk_6M      (clk_6M),
    .rst         (rst),
    .tx_en       (tx_en),
    .tx_fk       (tx_fk),
    .tx_sym      (tx_sym),
    .rx_en       (rx_en),
    .rx_fk       (rx_fk),
    .err_inj_en  (err_inj_en),
    .err_thresh  (err_thresh),
    .seed        (seed),
    .seed_load_p (seed_load_p),
    .clr_cnt_p   (clr_cnt_p),
    .rx_sym      (rx_sym),
    .rx_valid    (rx_valid),
    .collision   (collision),
    .col_cnt     (col_cnt),
    .err_cnt     (err_cnt)
  );

  initial clk_6M = 1'b0;
  always #5 clk_6M = ~clk_6M;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] m_lfsr  = 16'hACE1;
  logic        m_inj   = 1'b0;
  logic [15:0] exp_err = 16'h0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: predict this edge's injection decision and LFSR update from
  // the inputs currently applied, then sample 1 time unit after the edge.
  task automatic tick();
    m_inj = err_inj_en && (m_lfsr < err_thresh);
    if (rst) m_lfsr = 16'hACE1;
    else if (seed_load_p) m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    else m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    @(posedge clk_6M);
    #1;
  endtask

  function automatic logic [27:0] fk4(input int a0, a1, a2, a3);
    return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  function automatic logic [11:0] sym4(input int a0, a1, a2, a3);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // Link node0 -> node1 on fk 20 carrying 3'b110; node1 data sits at [5:3].
  task automatic set_link();
    tx_en = 4'b0001; tx_fk = fk4(20, 0, 0, 0); tx_sym = sym4(6, 0, 0, 0);
    rx_en = 4'b0010; rx_fk = fk4(0, 20, 0, 0);
  endtask

  task automatic run_link(input int n, input int valid_from, input string tag);
    logic ev;
    for (int k = 1; k <= n; k++) begin
      tick();
      ev = (k >= valid_from);
      if (ev && m_inj && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      chk({tag, "_valid"}, 32'(rx_valid), ev ? 32'h2 : 32'h0);
      chk({tag, "_sym"}, 32'(rx_sym[5:3]), ev ? 32'(3'b110 ^ {2'b00, m_inj}) : 32'h0);
    end
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
  endtask

  typedef struct {
    string       name;
    logic [3:0]  ten;
    logic [27:0] tfk;
    logic [11:0] tsym;
    logic [3:0]  ren;
    logic [27:0] rfk;
    logic [3:0]  ev;
    logic [11:0] esym;
    logic [3:0]  ecol;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_en = '0; tx_fk = '0; tx_sym = '0; rx_en = '0; rx_fk = '0;
    err_inj_en = 1'b0; err_thresh = '0; seed = '0; seed_load_p = 1'b0;
    clr_cnt_p = 1'b0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_sym", 32'(rx_sym), 32'h0);
    chk("rst_col", 32'(collision), 32'h0);
    chk("rst_col_cnt", 32'(col_cnt), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;

    // ---- steady-state match table ----
    vecs[0] = '{"basic", 4'b0001, fk4(5,0,0,0), sym4(5,0,0,0),
                4'b0111, fk4(5,5,6,0), 4'b0010, sym4(0,5,0,0), 4'b0000};
    vecs[1] = '{"col_pair", 4'b0101, fk4(9,0,9,0), sym4(1,0,2,0),
                4'b1001, fk4(9,0,0,9), 4'b0001, sym4(2,0,0,0), 4'b1000};
    vecs[2] = '{"rx_off", 4'b0001, fk4(5,0,0,0), sym4(7,0,0,0),
                4'b0000, fk4(5,5,5,5), 4'b0000, sym4(0,0,0,0), 4'b0000};
    vecs[3] = '{"ring", 4'b1111, fk4(1,2,3,4), sym4(1,2,3,4),
                4'b1111, fk4(2,3,4,1), 4'b1111, sym4(2,3,4,1), 4'b0000};
    vecs[4] = '{"col_three", 4'b0111, fk4(100,100,100,0), sym4(1,2,3,0),
                4'b1111, fk4(100,100,100,100), 4'b0000, sym4(0,0,0,0), 4'b1111};
    vecs[5] = '{"fk_max", 4'b0011, fk4(127,127,0,0), sym4(6,7,0,0),
                4'b0011, fk4(127,127,0,0), 4'b0011, sym4(7,6,0,0), 4'b0000};
    vecs[6] = '{"tx_off", 4'b0000, fk4(5,5,5,5), sym4(7,7,7,7),
                4'b1111, fk4(5,5,5,5), 4'b0000, sym4(0,0,0,0), 4'b0000};

    for (int v = 0; v < 7; v++) begin
      tx_en = vecs[v].ten; tx_fk = vecs[v].tfk; tx_sym = vecs[v].tsym;
      rx_en = vecs[v].ren; rx_fk = vecs[v].rfk;
      repeat (DLY + 1) tick();
      chk({vecs[v].name, "_valid"}, 32'(rx_valid), 32'(vecs[v].ev));
      chk({vecs[v].name, "_sym"}, 32'(rx_sym), 32'(vecs[v].esym));
      chk({vecs[v].name, "_col"}, 32'(collision), 32'(vecs[v].ecol));
    end

    // ---- latency: single symbol appears exactly DLY+1 edges later ----
    tx_en = '0; rx_en = 4'b0010; rx_fk = fk4(0, 5, 0, 0);
    repeat (DLY + 1) tick();
    tx_en = 4'b0001; tx_fk = fk4(5, 0, 0, 0); tx_sym = sym4(5, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      tx_en = '0;
      chk($sformatf("lat_valid_t%0d", k), 32'(rx_valid), (k == 5) ? 32'h2 : 32'h0);
      chk($sformatf("lat_sym_t%0d", k), 32'(rx_sym), (k == 5) ? 32'(sym4(0,5,0,0)) : 32'h0);
    end

    // ---- error injection at full threshold ----
    set_link();
    repeat (DLY + 2) tick();
    clr_cnt_p = 1'b1; seed = 16'h1234; seed_load_p = 1'b1;
    err_inj_en = 1'b1; err_thresh = 16'hFFFF;
    tick();
    clr_cnt_p = 1'b0; seed_load_p = 1'b0;
    exp_err = 16'h0;
    chk("clr_discard_err", 32'(err_cnt), 32'h0);
    chk("clr_edge_sym", 32'(rx_sym[5:3]), 32'(3'b110 ^ {2'b00, m_inj}));
    run_link(10, 1, "inj_full");

    // ---- injection disabled by zero threshold ----
    err_thresh = 16'h0; clr_cnt_p = 1'b1;
    tick();
    clr_cnt_p = 1'b0; exp_err = 16'h0;
    run_link(8, 1, "inj_zero");

    // ---- zero seed falls back to 16'hACE1, half threshold ----
    seed = 16'h0; seed_load_p = 1'b1; clr_cnt_p = 1'b1; err_thresh = 16'h8000;
    tick();
    seed_load_p = 1'b0; clr_cnt_p = 1'b0; exp_err = 16'h0;
    run_link(12, 1, "inj_seed0");

    // ---- reset mid-packet ----
    err_inj_en = 1'b0;
    set_link();
    for (int s = 1; s <= 6; s++) begin
      tx_sym = sym4(s, 0, 0, 0);
      tick();
    end
    tx_en = '0;
    chk("pre_rst_valid", 32'(rx_valid), 32'h2);
    chk("pre_rst_sym", 32'(rx_sym[5:3]), 32'h2);
    #1 rst = 1'b1; m_lfsr = 16'hACE1;
    #1;
    chk("async_rst_valid", 32'(rx_valid), 32'h0);
    chk("async_rst_sym", 32'(rx_sym), 32'h0);
    tick(); tick();
    rst = 1'b0;
    set_link();
    err_inj_en = 1'b1; err_thresh = 16'h8000; exp_err = 16'h0;
    run_link(12, DLY + 1, "post_rst");

    // ---- collision counter with clear during an active collision ----
    err_inj_en = 1'b0;
    tx_en = 4'b0101; tx_fk = fk4(9, 0, 9, 0); tx_sym = sym4(1, 0, 2, 0);
    rx_en = 4'b1000; rx_fk = fk4(0, 0, 0, 9);
    repeat (DLY + 2) tick();
    clr_cnt_p = 1'b1;
    tick();
    clr_cnt_p = 1'b0;
    chk("col_clr_cnt", 32'(col_cnt), 32'h0);
    chk("col_flag", 32'(collision), 32'h8);
    chk("col_valid", 32'(rx_valid), 32'h0);
    chk("col_sym", 32'(rx_sym), 32'h0);
    repeat (10) tick();
    chk("col_cnt_10", 32'(col_cnt), 32'd10);

    // ---- saturation: four colliding receivers per cycle ----
    tx_en = 4'b0111; tx_fk = fk4(100, 100, 100, 0);
    rx_en = 4'b1111; rx_fk = fk4(100, 100, 100, 100);
    repeat (17000) tick();
    chk("col_sat", 32'(col_cnt), 32'hFFFF);
    repeat (5) tick();
    chk("col_sat_hold", 32'(col_cnt), 32'hFFFF);
    clr_cnt_p = 1'b1;
    tick();
    clr_cnt_p = 1'b0;
    chk("col_sat_clr", 32'(col_cnt), 32'h0);
    tick();
    chk("col_resume_1", 32'(col_cnt), 32'd4);
    tick();
    chk("col_resume_2", 32'(col_cnt), 32'd8);
    chk("err_cnt_idle", 32'(err_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
